// File: rtl/regfile_lanes_if.sv
// regfile_lanes_if: bus between the vector decode stage / lane ALUs and the
// lane-masked register file.
//   master modport (decode/ALU side): drives W_En, W_Addr, W_Mask, WR,
//                                     R_Addr, S_Addr; receives R, S, Ready.
//   slave modport (register file):    the reverse.
interface regfile_lanes_if #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned AW    = 5,
    parameter int unsigned LANES = 8
);
    logic             W_En;
    logic [AW-1:0]    W_Addr;
    logic [LANES-1:0] W_Mask;
    logic [WIDTH-1:0] WR;
    logic [AW-1:0]    R_Addr;
    logic [AW-1:0]    S_Addr;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] S;
    logic             Ready;

    modport master (
        output W_En, W_Addr, W_Mask, WR, R_Addr, S_Addr,
        input  R, S, Ready
    );

    modport slave (
        input  W_En, W_Addr, W_Mask, WR, R_Addr, S_Addr,
        output R, S, Ready
    );
endinterface

// File: rtl/regfile_lanes.sv
// regfile_lanes: two-read/one-write register file with per-lane write masks
// and a post-reset clear sequencer.
//   clk    : rising-edge clock for all state
//   reset  : asynchronous, active-high reset (restarts the clear sequence)
//   bus    : regfile_lanes_if.slave
//            W_En/W_Addr/W_Mask/WR  write request, lane i covers WR[i*LW +: LW]
//            R_Addr/S_Addr -> R/S   combinational read ports (0 while clearing
//                                   or for addresses >= DEPTH)
//            Ready                  registered, high once every entry is zeroed
// Optional feature macro: REGFILE_BYPASS_EN -- forwards the merged write word
// to R/S in the write cycle when the read address matches the write address.
module regfile_lanes #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned LANES = 8
) (
    input logic             clk,
    input logic             reset,
    regfile_lanes_if.slave  bus
);

    localparam int unsigned LW        = WIDTH / LANES;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    state_e           state_q;
    logic [AW-1:0]    cp_q;
    logic             ready_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             w_in_range;
    logic             r_in_range;
    logic             s_in_range;
    logic [WIDTH-1:0] w_old;
    logic [WIDTH-1:0] wr_word_d;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] s_data;

    assign w_in_range = 32'(bus.W_Addr) < DEPTH;
    assign r_in_range = 32'(bus.R_Addr) < DEPTH;
    assign s_in_range = 32'(bus.S_Addr) < DEPTH;

    // Clear sequencer: one entry per edge, RUN entered on the edge that
    // clears the last entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            cp_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (cp_q == LAST_IDX) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                        cp_q    <= '0;
                    end else begin
                        cp_q <= cp_q + 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= CLEAR;
                    cp_q    <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Lane merge of the addressed word with WR; used for the array update
    // and, when enabled, for same-cycle forwarding.
    always_comb begin
        w_old = '0;
        if (w_in_range) begin
            w_old = mem_q[bus.W_Addr];
        end
        wr_word_d = w_old;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (bus.W_Mask[i]) begin
                wr_word_d[i*LW +: LW] = bus.WR[i*LW +: LW];
            end
        end
    end

    // Array has no reset of its own; the sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[cp_q] <= '0;
        end else if (bus.W_En && w_in_range) begin
            mem_q[bus.W_Addr] <= wr_word_d;
        end
    end

    always_comb begin
        r_data = '0;
        s_data = '0;
        if (state_q == RUN) begin
            if (r_in_range) begin
                r_data = mem_q[bus.R_Addr];
            end
            if (s_in_range) begin
                s_data = mem_q[bus.S_Addr];
            end
`ifdef REGFILE_BYPASS_EN
            if (bus.W_En && w_in_range && (bus.W_Addr == bus.R_Addr)) begin
                r_data = wr_word_d;
            end
            if (bus.W_En && w_in_range && (bus.W_Addr == bus.S_Addr)) begin
                s_data = wr_word_d;
            end
`else
`endif
        end
    end

    assign bus.R     = r_data;
    assign bus.S     = s_data;
    assign bus.Ready = ready_q;

endmodule

// File: tb/tb_regfile_lanes.sv
// Bench for regfile_lanes: two instances (DEPTH=32 and DEPTH=24) share one
// stimulus stream and are compared each mid-cycle against a reference model
// of the register file contents and the clear delay.
module tb_regfile_lanes;

    logic         clk;
    logic         reset;
    logic         w_en;
    logic [4:0]   w_addr;
    logic [7:0]   w_mask;
    logic [255:0] wr;
    logic [4:0]   r_addr;
    logic [4:0]   s_addr;

    int checks   = 0;
    int failures = 0;

    regfile_lanes_if #(.WIDTH(256), .AW(5), .LANES(8)) bus0 ();
    regfile_lanes_if #(.WIDTH(256), .AW(5), .LANES(8)) bus1 ();

    assign bus0.W_En   = w_en;
    assign bus0.W_Addr = w_addr;
    assign bus0.W_Mask = w_mask;
    assign bus0.WR     = wr;
    assign bus0.R_Addr = r_addr;
    assign bus0.S_Addr = s_addr;
    assign bus1.W_En   = w_en;
    assign bus1.W_Addr = w_addr;
    assign bus1.W_Mask = w_mask;
    assign bus1.WR     = wr;
    assign bus1.R_Addr = r_addr;
    assign bus1.S_Addr = s_addr;

    regfile_lanes #(.WIDTH(256), .DEPTH(32), .AW(5), .LANES(8)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    regfile_lanes #(.WIDTH(256), .DEPTH(24), .AW(5), .LANES(8)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents seen after the clear completes (all zero),
    // plus a count of edges since reset release; ready once count >= depth.
    logic [255:0] mmem [2][32];
    int           cnt  [2];
    int           dep  [2];
    initial begin
        dep[0] = 32;
        dep[1] = 24;
    end

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                cnt[k] <= 0;
                for (int a = 0; a < 32; a++) mmem[k][a] <= '0;
            end else if (cnt[k] < dep[k]) begin
                cnt[k] <= cnt[k] + 1;
            end else if (w_en && int'(w_addr) < dep[k]) begin
                for (int l = 0; l < 8; l++)
                    if (w_mask[l]) mmem[k][w_addr][l*32 +: 32] <= wr[l*32 +: 32];
            end
        end
    end

    function automatic logic [255:0] exp_rd(input int k, input logic [4:0] a);
        logic [255:0] v;
        if (cnt[k] < dep[k] || int'(a) >= dep[k]) return '0;
        v = mmem[k][a];
`ifdef REGFILE_BYPASS_EN
        if (w_en && w_addr == a)
            for (int l = 0; l < 8; l++)
                if (w_mask[l]) v[l*32 +: 32] = wr[l*32 +: 32];
`endif
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("ready0", 256'(bus0.Ready), 256'(cnt[0] >= dep[0]));
        chk("ready1", 256'(bus1.Ready), 256'(cnt[1] >= dep[1]));
        chk("R0", bus0.R, exp_rd(0, r_addr));
        chk("S0", bus0.S, exp_rd(0, s_addr));
        chk("R1", bus1.R, exp_rd(1, r_addr));
        chk("S1", bus1.S, exp_rd(1, s_addr));
    end

    task automatic ready_sweep(input string nm);
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk); #1;
            chk({nm, "_ready0"}, 256'(bus0.Ready), 256'(e >= 32));
            chk({nm, "_ready1"}, 256'(bus1.Ready), 256'(e >= 24));
            if (e == 10) w_en = 1'b0;
        end
    endtask

    logic [255:0] v2;
    logic [255:0] exp5;

    initial begin
        reset  = 1'b1;
        w_en   = 1'b0;
        w_addr = '0;
        w_mask = '0;
        wr     = '0;
        r_addr = '0;
        s_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 256'(bus0.Ready), 256'(0));
        chk("rst_R", bus0.R, '0);

        // Release reset with a write pending: writes during clear are dropped.
        reset  = 1'b0;
        w_en   = 1'b1;
        w_addr = 5'd3;
        wr     = '1;
        w_mask = 8'hFF;
        ready_sweep("clr");

        for (int a = 0; a < 32; a++) begin
            r_addr = 5'(a);
            s_addr = 5'(31 - a);
            #1;
            chk("sweep_R", bus0.R, '0);
            chk("sweep_S", bus0.S, '0);
        end
        r_addr = 5'd3;
        #1;
        chk("clr_drop_addr3", bus0.R, '0);

        // Lane-masked overwrite of reg 5.
        @(posedge clk); #1;
        w_en = 1'b1; w_addr = 5'd5; w_mask = 8'hFF; wr = {8{32'hAAAA_AAAA}};
        @(posedge clk); #1;
        w_mask = 8'h0F; wr = {8{32'h5555_5555}};
        @(posedge clk); #1;
        w_en = 1'b0; r_addr = 5'd5; s_addr = 5'd5;
        #1;
        exp5 = {{4{32'hAAAA_AAAA}}, {4{32'h5555_5555}}};
        chk("mask_R5", bus0.R, exp5);
        chk("mask_S5", bus0.S, exp5);
        chk("model_pin5", exp_rd(0, 5'd5), exp5);

        // Same-cycle write/read of reg 7.
        @(posedge clk); #1;
        w_en = 1'b1; w_addr = 5'd7; w_mask = 8'h01; r_addr = 5'd7;
        wr = {{7{32'hDEAD_BEEF}}, 32'h1234_5678};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_R7", bus0.R, {224'd0, 32'h1234_5678});
`else
        chk("same_cycle_R7", bus0.R, '0);
`endif
        @(posedge clk); #1;
        w_en = 1'b0;
        #1;
        chk("next_cycle_R7", bus0.R, {224'd0, 32'h1234_5678});

        // Out-of-range write for the DEPTH=24 instance.
        w_en = 1'b1; w_addr = 5'd30; w_mask = 8'hFF; wr = '1;
        @(posedge clk); #1;
        w_en = 1'b0; r_addr = 5'd30; s_addr = 5'd30;
        #1;
        chk("oor_R30_d24", bus1.R, '0);
        chk("oor_S30_d24", bus1.S, '0);
        chk("inrange_R30_d32", bus0.R, '1);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            w_en   = ($urandom_range(0, 3) != 0);
            w_addr = 5'($urandom_range(0, 31));
            w_mask = 8'($urandom);
            for (int l = 0; l < 8; l++) wr[l*32 +: 32] = $urandom;
            r_addr = ($urandom_range(0, 3) == 0) ? w_addr : 5'($urandom_range(0, 31));
            s_addr = ($urandom_range(0, 3) == 0) ? w_addr : 5'($urandom_range(0, 31));
        end

        // Mid-run reset pulse with reg 2 holding data.
        @(posedge clk); #1;
        v2 = {8{32'hC0DE_0001}};
        w_en = 1'b1; w_addr = 5'd2; w_mask = 8'hFF; wr = v2;
        @(posedge clk); #1;
        w_en = 1'b0; r_addr = 5'd2; s_addr = 5'd2;
        #1;
        chk("pre_rst_R2", bus0.R, v2);
        #1;
        reset = 1'b1;
        #1;
        chk("async_ready0", 256'(bus0.Ready), 256'(0));
        chk("async_ready1", 256'(bus1.Ready), 256'(0));
        chk("async_R2", bus0.R, '0);
        #3;
        reset = 1'b0;
        ready_sweep("rerun");
        r_addr = 5'd2;
        #1;
        chk("post_rst_R2", bus0.R, '0);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_lanes.md
# regfile_lanes

Parametrised two-read/one-write register file: successor to the fixed 32×256 file in the vector datapath. Adds configurable width, depth and lane count, per-lane write masking, and a post-reset clear sequencer that zeroes every entry before the file accepts writes. Read ports stay combinational. Write-to-read forwarding is optional. It sits between the vector decode stage (addresses) and the lane ALUs (operands/results).

## Interface
- `WIDTH`, 256, register width in bits; must be a multiple of `LANES`.
- `DEPTH`, 32, number of registers; must be ≥2.
- `AW`, 5, address width; `2**AW >= DEPTH`.
- `LANES`, 8, write-mask granularity; lane width `LW = WIDTH/LANES`.
- `clk  in  1`  rising-edge clock for all state.
- `reset  in  1`  asynchronous, active-high reset.
- `W_En  in  1`  write request.
- `W_Addr  in  AW`  write address.
- `W_Mask  in  LANES`  lane enables; bit i covers `WR[i*LW +: LW]`.
- `WR  in  WIDTH`  write data.
- `R_Addr  in  AW`  read port R address.
- `S_Addr  in  AW`  read port S address.
- `R  out  WIDTH`  read data, port R (combinational).
- `S  out  WIDTH`  read data, port S (combinational).
- `Ready  out  1`  high when clear sequence is complete and writes are accepted.

## Operation
- FSM states: CLEAR, RUN.
- Reset asserted (async): state←CLEAR, clear pointer `cp`←0, `Ready`←0. Array contents are not reset directly; the sequencer clears them.
- CLEAR: each rising edge writes all-zero to `reg[cp]` and increments `cp`. On the edge that clears `DEPTH-1`, state←RUN and `Ready`←1. Total: `DEPTH` edges after reset release.
- CLEAR: `W_En` is ignored; writes are dropped, not queued. `R`/`S` are forced to 0.
- RUN: on a rising edge with `W_En=1`, for each lane i with `W_Mask[i]=1`, lane i of `reg[W_Addr]` ← lane i of `WR`. Unmasked lanes hold. `W_Mask=0` is a legal no-op.
- RUN reads: `R = reg[R_Addr]`, `S = reg[S_Addr]`, combinational. R and S may share an address.
- Out-of-range address (`addr >= DEPTH`): a write is dropped, and a read returns 0.
- Reset mid-CLEAR or mid-RUN: returns immediately to CLEAR with `cp=0`. The full clear sequence restarts.
- `Ready` is a registered state decode; it never glitches.

## Timing
- Reset values: `Ready=0`, `R=0`, `S=0` (forced by CLEAR), `cp=0`.
- `Ready` rises `DEPTH` clock edges after reset deasserts (32 with defaults).
- Write latency: data is visible on R/S in the cycle after the write edge (without bypass).
- Read latency: 0 cycles (combinational from address and array).
- Simultaneous write and read of the same address in RUN: behaviour is set by `REGFILE_BYPASS_EN`, below.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - In RUN with `W_En=1` and `W_Addr==R_Addr` (in range), R shows the merged word combinationally in the same cycle: masked lanes from `WR`, unmasked lanes from `reg[W_Addr]`.
  - S is forwarded the same way.
  - No forwarding occurs in CLEAR.
- Not defined: R/S show the pre-write array contents until the write edge. The new value appears the following cycle.

## Test plan
- Reset, then release; sample `Ready` each edge. Required: `Ready=0` for edges 1..31, `Ready=1` after edge 32. Reading every address afterwards returns 0.
- In CLEAR, drive `W_En=1`, `W_Addr=3`, `WR=all-ones`, `W_Mask=8'hFF`. After `Ready`, R at address 3 must be 0.
- RUN: write `reg[5]` = `{8{32'hAAAA_AAAA}}` with mask `8'hFF`, then write `WR={8{32'h5555_5555}}` with `W_Mask=8'h0F`. Required: `reg[5]` = upper four lanes `AAAA_AAAA`, lower four lanes `5555_5555`. Reading with `R_Addr=S_Addr=5` gives identical R and S.
- Same-cycle write and read of address 7, mask `8'h01`, `WR` lane0 = `32'h1234_5678`, prior `reg[7]=0`:
  - With `REGFILE_BYPASS_EN`: R lane0 = `1234_5678` in the write cycle.
  - Without it: R = 0 in that cycle and lane0 = `1234_5678` the next cycle.
- Mid-RUN, with `reg[2]` nonzero, pulse reset for half a cycle. Required: `Ready` drops to 0 asynchronously and the clear restarts from 0. After 32 edges, `reg[2]=0`.
- Instantiate with `DEPTH=24`, `AW=5`. Writing address 30 is dropped, and reading address 30 returns 0. `Ready` rises 24 edges after reset.
